// File: rtl/board_pkg.sv
// Shared board definitions: geometry, widths, board type and scanner states.
// The board state block and the scanner both build on these.
package board_pkg;

  localparam int BOARD_N = 11;
  localparam int COORD_W = 4;
  localparam int IDX_W   = 7;

  // board[x][y], 1 = stone present.
  typedef logic [0:BOARD_N-1][0:BOARD_N-1] board_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/board_cursor.sv
// Board walk counter: y inner, x outer, with a running flat index so that
// x*N + y never has to be formed with a multiplier.
module board_cursor
  import board_pkg::*;
#(
  parameter int N  = BOARD_N,
  parameter int CW = COORD_W,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic y_end;

  assign y_end = (y == CW'(N - 1));
  assign last  = y_end && (x == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end else if (step) begin
      // Wrapping after the last cell keeps x inside the board for indexing.
      if (last) begin
        x   <= '0;
        y   <= '0;
        idx <= '0;
      end else if (y_end) begin
        x   <= x + CW'(1);
        y   <= '0;
        idx <= idx + IW'(1);
      end else begin
        y   <= y + CW'(1);
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/board_scanner.sv
// Snapshots the occupancy board on start and streams one feature per
// occupied cell, in y-inner / x-outer order, to the NNUE front-end.
module board_scanner
  import board_pkg::*;
#(
  parameter int N  = BOARD_N,
  parameter int CW = COORD_W,
  parameter int IW = IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:N-1][0:N-1]     board,
  output logic                    feat_valid,
  input  logic                    feat_ready,
  output logic [CW-1:0]           feat_x,
  output logic [CW-1:0]           feat_y,
  output logic [IW-1:0]           feat_idx,
  output logic                    busy,
  output logic                    done,
  output logic [IW-1:0]           count,
  output scan_state_t             dbg_state
);

  scan_state_t         state;
  logic [0:N-1][0:N-1] snap;
  logic [CW-1:0]       cur_x;
  logic [CW-1:0]       cur_y;
  logic [IW-1:0]       cur_idx;
  logic                cur_last;
  logic                cell_occ;
  logic                accept_start;
  logic                step;

  assign accept_start = (state == ST_IDLE) && start;
  assign cell_occ     = snap[cur_x][cur_y];

  // Stream handshake: a feature transfers on any cycle with feat_valid and
  // feat_ready both high. feat_valid depends only on registered state and the
  // snapshot, never on feat_ready, and once raised the feature holds until
  // it transfers. Empty cells are skipped without presenting anything.
  assign feat_valid = (state == ST_SCAN) && cell_occ;
  assign step       = (state == ST_SCAN) && (!cell_occ || feat_ready);

  assign feat_x    = cur_x;
  assign feat_y    = cur_y;
  assign feat_idx  = cur_idx;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  board_cursor #(
    .N  (N),
    .CW (CW),
    .IW (IW)
  ) u_cursor (
    .clk   (clk),
    .rst   (rst),
    .clear (accept_start),
    .step  (step),
    .x     (cur_x),
    .y     (cur_y),
    .idx   (cur_idx),
    .last  (cur_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      snap  <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap  <= board;
            count <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (feat_valid && feat_ready) count <= count + IW'(1);
          if (step && cur_last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: empty, short row, stalled diagonal,
// full board, perturbed rescan and mid-scan reset.
module tb_board_scanner;
  import board_pkg::*;

  localparam int N  = BOARD_N;
  localparam int IW = IDX_W;
  localparam int CW = COORD_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  board_t        board;
  logic          feat_valid;
  logic          feat_ready;
  logic [CW-1:0] feat_x;
  logic [CW-1:0] feat_y;
  logic [IW-1:0] feat_idx;
  logic          busy;
  logic          done;
  logic [IW-1:0] count;
  scan_state_t   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] got_idx[$];
  logic [CW-1:0] got_x[$];
  logic [CW-1:0] got_y[$];
  int            got_cyc[$];

  always #5 clk = ~clk;

  board_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board      (board),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_x     (feat_x),
    .feat_y     (feat_y),
    .feat_idx   (feat_idx),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns in SCAN cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ready_mode 0: ready high; 1: ready alternates 0/1 per presented cycle.
  // perturb: clear board and re-pulse start mid-scan and at done.
  task automatic run_scan(input int ready_mode, input bit perturb, output int done_cyc);
    bit            held;
    bit            tog;
    logic [IW-1:0] held_idx;
    held = 0;
    tog = 0;
    held_idx = '0;
    done_cyc = -1;
    got_idx.delete(); got_x.delete(); got_y.delete(); got_cyc.delete();
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      if (cyc == 1) check("busy_scan", int'(busy), 1);
      feat_ready = 1'b1;
      if (ready_mode == 1 && feat_valid) begin
        feat_ready = tog;
        tog = ~tog;
      end
      if (held) begin
        check("hold_valid", int'(feat_valid), 1);
        check("hold_idx", int'(feat_idx), int'(held_idx));
      end
      if (feat_valid) begin
        if (feat_ready) begin
          got_idx.push_back(feat_idx);
          got_x.push_back(feat_x);
          got_y.push_back(feat_y);
          got_cyc.push_back(cyc);
          held = 0;
        end else begin
          held = 1;
          held_idx = feat_idx;
        end
      end else begin
        held = 0;
      end
      if (done) done_cyc = cyc;
      start = 1'b0;
      if (perturb && (cyc == 10 || done)) begin
        start = 1'b1;
        board = '0;
      end
      tick();
    end
    start = 1'b0;
    feat_ready = 1'b1;
    if (done_cyc < 0) check("done_timeout", 0, 1);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
  endtask

  task automatic compare_stream(input string tag, input bit check_cyc);
    check({tag, "_n"}, got_idx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_idx.size(); i++) begin
      check({tag, "_idx"}, int'(got_idx[i]), int'(exp_q[i]));
      check({tag, "_x"}, int'(got_x[i]), int'(exp_q[i]) / N);
      check({tag, "_y"}, int'(got_y[i]), int'(exp_q[i]) % N);
      if (check_cyc) check({tag, "_cyc"}, got_cyc[i], int'(exp_q[i]) + 1);
    end
  endtask

  initial begin
    int  dc;
    bit  saw_done;
    rst = 1'b1;
    start = 1'b0;
    board = '0;
    feat_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(feat_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);

    // Empty board.
    board = '0;
    pulse_start();
    run_scan(0, 0, dc);
    exp_q.delete();
    compare_stream("empty", 1);
    check("empty_done_cyc", dc, 122);
    check("empty_count", int'(count), 0);

    // Stones (0,0)..(0,4).
    board = '0;
    for (int y = 0; y < 5; y++) board[0][y] = 1'b1;
    pulse_start();
    run_scan(0, 0, dc);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(IW'(i));
    compare_stream("row", 1);
    check("row_done_cyc", dc, 122);
    check("row_count", int'(count), 5);

    // Diagonal with each feature stalled once before acceptance.
    board = '0;
    for (int k = 0; k < 6; k++) board[k + 1][k] = 1'b1;
    pulse_start();
    run_scan(1, 0, dc);
    exp_q.delete();
    exp_q.push_back(7'd11); exp_q.push_back(7'd23); exp_q.push_back(7'd35);
    exp_q.push_back(7'd47); exp_q.push_back(7'd59); exp_q.push_back(7'd71);
    compare_stream("diag", 0);
    check("diag_done_cyc", dc, 128);
    check("diag_count", int'(count), 6);

    // Full board.
    board = '1;
    pulse_start();
    run_scan(0, 0, dc);
    exp_q.delete();
    for (int i = 0; i < N * N; i++) exp_q.push_back(IW'(i));
    compare_stream("full", 1);
    check("full_done_cyc", dc, 122);
    check("full_count", int'(count), 121);

    // Same row pattern, with board cleared and start re-pulsed mid-scan.
    board = '0;
    for (int y = 0; y < 5; y++) board[0][y] = 1'b1;
    board[3][7] = 1'b1;
    pulse_start();
    run_scan(0, 1, dc);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(IW'(i));
    exp_q.push_back(7'd40);
    compare_stream("perturb", 1);
    check("perturb_done_cyc", dc, 122);
    check("perturb_count", int'(count), 6);

    // Reset at SCAN cycle 40 of a full-board scan.
    board = '1;
    pulse_start();
    for (int cyc = 1; cyc < 40; cyc++) tick();
    check("pre_rst_count", int'(count), 39);
    check("pre_rst_idx", int'(feat_idx), 39);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", int'(feat_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_count", int'(count), 0);
    saw_done = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done || feat_valid) saw_done = 1;
      tick();
    end
    check("mid_rst_quiet", int'(saw_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_scanner.md
# board_scanner

Read-side companion of the board state block. On a `start` pulse it snapshots the 11x11 occupancy board and walks it in fixed order. For every occupied cell it emits one feature coordinate and flat index over a valid/ready stream. The NNUE accumulator front-end consumes that stream to rebuild its input features after a board update.

## Interface
- `N`, 11, board side length; cells are addressed by x, y in 0..N-1.
- `CW`, 4, width of the x/y coordinate outputs; must satisfy 2^CW >= N.
- `IW`, 7, width of the flat index; must satisfy 2^IW >= N*N.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  scan request pulse; sampled only in IDLE.
- `board`  in  N*N  packed occupancy, `board[x][y]`, 1 = stone present; sampled only on an accepted `start`.
- `feat_valid`  out  1  a feature is presented this cycle.
- `feat_ready`  in  1  the consumer accepts the feature this cycle.
- `feat_x`  out  CW  x of the presented cell.
- `feat_y`  out  CW  y of the presented cell.
- `feat_idx`  out  IW  flat index, x*N + y.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse at scan end.
- `count`  out  IW  features emitted by the current or last scan.

## Operation
- The FSM has three states: IDLE, SCAN and DONE. An encoded enum is used.
- IDLE with `start`=1:
  - the snapshot register takes `board`;
  - the cursor goes to (0,0);
  - `count` goes to 0;
  - the next state is SCAN.
- `start` in SCAN or DONE is ignored and has no side effect.
- SCAN, cursor cell empty in the snapshot: `feat_valid`=0 and the cursor advances this cycle.
- SCAN, cursor cell occupied:
  - `feat_valid`=1, with `feat_x`/`feat_y`/`feat_idx` driven from the cursor;
  - the cursor advances only when `feat_ready`=1, and `count` increments on that cycle;
  - while `feat_ready`=0, all feature outputs hold stable.
- Cursor order is y inner, x outer. From (x, N-1) the cursor goes to (x+1, 0). Advancing from (N-1, N-1) moves the FSM to DONE.
- DONE lasts one cycle: `done`=1, then IDLE. `count` keeps its value until the next accepted `start`.
- Changes to `board` during SCAN are invisible; only the snapshot is read.
- `feat_x`/`feat_y`/`feat_idx` are don't-care whenever `feat_valid`=0. The bench must not check them then.
- `feat_idx` is computed from the cursor as x*N + y. No multiplier is allowed: keep a running index register that increments with every cursor step.

## Timing
- Reset values: `feat_valid`=0, `busy`=0, `done`=0, `count`=0, cursor=(0,0), snapshot=0, state IDLE.
- Reset asserted mid-scan aborts on the next edge: no `done` and no further `feat_valid`.
- If `start` is accepted on edge t:
  - SCAN covers cells 0..N*N-1 in the cycles after t;
  - with `feat_ready` tied high, one cell is visited per cycle (121 SCAN cycles for N=11);
  - `done` is high in cycle t+N*N+1, and `busy` falls after it.
- Each low-`feat_ready` cycle on an occupied cell adds exactly one cycle of latency.
- `feat_valid` is a combinational decode of registered state and the snapshot. There is no dependency from `feat_ready` to `feat_valid` (no comb loop).
- `start` asserted in the same cycle as `done` is ignored. A new scan needs `start` in IDLE.
- `count` is at most N*N = 121, which fits in IW bits. No wrap is possible.

## Structure
- Shared package `board_pkg` holds: `BOARD_N`=11; the coordinate and index widths; the `board_t` packed [0:N-1][0:N-1] typedef; and the scanner state enum. The board state block already uses `board_t`.
- One sub-module, `board_cursor`. It is an x/y/index counter with a `step` input and a `last` output. Everything else stays in `board_scanner`.

## Test plan
- Empty board, `feat_ready`=1, `start` -> no `feat_valid` for 121 cycles, then `done` one cycle, `count`=0.
- Stones at (0,0)..(0,4) -> five features with idx 0,1,2,3,4 on consecutive SCAN cycles 1..5, then `count`=5.
- Diagonal stones (1,0),(2,1),(3,2),(4,3),(5,4),(6,5) with `feat_ready` toggling 1/0 -> idx 11,23,35,47,59,71 in order. Each idx is held stable until accepted, and `count`=6.
- Full board, `feat_ready`=1 -> 121 back-to-back features idx 0..120, then `done`, `count`=121.
- `board` cleared and `start` re-pulsed during SCAN -> output sequence identical to the unperturbed run.
- `rst` pulsed at SCAN cycle 40 -> on the next edge `feat_valid`=0, `busy`=0, `count`=0, and no `done` ever appears.
